// File: rtl/amp_sched_pkg.sv
// -----------------------------------------------------------------------------
// amp_sched_pkg
// Shared definitions for the amp_column_scheduler block:
//   - DATA_W_DEF / TIMEOUT_CYCLES_DEF : default element width and watchdog limit
//   - amp_w()                         : modulus width, one bit wider than an element
//   - amp_state_e                     : scheduler FSM states and their encoding
// -----------------------------------------------------------------------------
package amp_sched_pkg;

   localparam int DATA_W_DEF         = 16;
   localparam int TIMEOUT_CYCLES_DEF = 64;

   // sqrt(a1^2 + a2^2) of two DATA_W operands needs exactly one extra bit.
   function automatic int amp_w(input int data_w);
      return data_w + 1;
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ISSUE_C1 = 3'd1,
      ST_WAIT_C1  = 3'd2,
      ST_ISSUE_C2 = 3'd3,
      ST_WAIT_C2  = 3'd4,
      ST_DONE     = 3'd5
   } amp_state_e;

endpackage

// File: rtl/amp_sched_watchdog.sv
// -----------------------------------------------------------------------------
// amp_sched_watchdog
// Cycle counter that flags when LIMIT enabled cycles have elapsed since the
// last load.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : restart the count (takes priority over en_i)
//   en_i          : count this cycle
//   expire_o      : high during the LIMIT-th enabled cycle after a load
// -----------------------------------------------------------------------------
module amp_sched_watchdog #(
   parameter int unsigned LIMIT = 64
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic load_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturates at LAST so a stalled enable cannot wrap and re-arm.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LAST)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/amp_column_scheduler.sv
// -----------------------------------------------------------------------------
// amp_column_scheduler
// Shares one modulus unit between both columns of a 2x2 matrix: latches the
// four elements, requests |col1| then |col2| from the shared unit and presents
// both moduli with a single O_amps_valid pulse.
//
// Optional feature: define AMP_SCHED_TIMEOUT_EN to add a per-request watchdog
// (TIMEOUT_CYCLES). Without it O_timeout is tied 0 and WAIT states hold forever.
//
// Ports:
//   I_sys_clk, I_sys_rstn          clock, asynchronous active-low reset
//   I_a_matrix_ready               1-cycle pulse, I_a11..I_a22 valid
//   I_a11, I_a21, I_a12, I_a22     matrix elements (DATA_W)
//   O_amp_ena                      1-cycle request to the shared unit
//   O_amp_a1, O_amp_a2             operands, held from request until result
//   I_amp, I_amp_valid             shared-unit result (DATA_W+1) and its pulse
//   O_column_1_amp, O_column_2_amp captured moduli (DATA_W+1)
//   O_amps_valid                   1-cycle pulse, both moduli valid
//   O_busy                         high from the cycle after acceptance to DONE
//   O_overrun                      1-cycle pulse, a matrix-ready was dropped
//   O_timeout                      1-cycle pulse, watchdog expired
//   O_dbg_state                    current FSM state
//
// Handshake: every strobe here is a single-cycle pulse with no back-pressure.
// A matrix-ready is accepted only in IDLE, otherwise it is dropped and flagged
// by O_overrun one cycle later. The shared unit must answer at least one cycle
// after O_amp_ena; I_amp_valid is honoured only in WAIT_C1/WAIT_C2.
// -----------------------------------------------------------------------------
module amp_column_scheduler
   import amp_sched_pkg::*;
#(
   parameter int DATA_W         = DATA_W_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic              I_sys_clk,
   input  logic              I_sys_rstn,
   input  logic              I_a_matrix_ready,
   input  logic [DATA_W-1:0] I_a11,
   input  logic [DATA_W-1:0] I_a21,
   input  logic [DATA_W-1:0] I_a12,
   input  logic [DATA_W-1:0] I_a22,
   output logic              O_amp_ena,
   output logic [DATA_W-1:0] O_amp_a1,
   output logic [DATA_W-1:0] O_amp_a2,
   input  logic [DATA_W:0]   I_amp,
   input  logic              I_amp_valid,
   output logic [DATA_W:0]   O_column_1_amp,
   output logic [DATA_W:0]   O_column_2_amp,
   output logic              O_amps_valid,
   output logic              O_busy,
   output logic              O_overrun,
   output logic              O_timeout,
   output amp_state_e        O_dbg_state
);

   localparam int AMP_W = amp_w(DATA_W);

   amp_state_e        state_q, state_d;
   logic [DATA_W-1:0] a11_q, a21_q, a12_q, a22_q;
   logic [AMP_W-1:0]  col1_q, col2_q;
   logic              overrun_q;
   logic              timeout_hit;
   logic              accept;
   logic              cap1, cap2;

`ifdef AMP_SCHED_TIMEOUT_EN
   logic wd_load, wd_en;

   // Reload while issuing so the count starts at zero on WAIT entry.
   assign wd_load = (state_q == ST_ISSUE_C1) || (state_q == ST_ISSUE_C2);
   assign wd_en   = (state_q == ST_WAIT_C1)  || (state_q == ST_WAIT_C2);

   amp_sched_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk_i    (I_sys_clk),
      .rst_ni   (I_sys_rstn),
      .load_i   (wd_load),
      .en_i     (wd_en),
      .expire_o (timeout_hit)
   );

   // Expiry wins over a result arriving in the same cycle; that result is dropped.
   assign O_timeout = timeout_hit;
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout_hit        = 1'b0;
   assign O_timeout          = 1'b0;
`endif

   assign accept = (state_q == ST_IDLE) && I_a_matrix_ready;
   assign cap1   = (state_q == ST_WAIT_C1) && I_amp_valid && !timeout_hit;
   assign cap2   = (state_q == ST_WAIT_C2) && I_amp_valid && !timeout_hit;

   // State register
   always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
      if (!I_sys_rstn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (I_a_matrix_ready) state_d = ST_ISSUE_C1;
         ST_ISSUE_C1: state_d = ST_WAIT_C1;
         ST_WAIT_C1: begin
            if (timeout_hit)      state_d = ST_IDLE;
            else if (I_amp_valid) state_d = ST_ISSUE_C2;
         end
         ST_ISSUE_C2: state_d = ST_WAIT_C2;
         ST_WAIT_C2: begin
            if (timeout_hit)      state_d = ST_IDLE;
            else if (I_amp_valid) state_d = ST_DONE;
         end
         ST_DONE:     state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Output decode: Moore outputs from the state register only.
   always_comb begin
      O_amp_ena    = 1'b0;
      O_amp_a1     = '0;
      O_amp_a2     = '0;
      O_amps_valid = 1'b0;
      O_busy       = (state_q != ST_IDLE);
      case (state_q)
         ST_ISSUE_C1: begin
            O_amp_ena = 1'b1;
            O_amp_a1  = a11_q;
            O_amp_a2  = a21_q;
         end
         ST_WAIT_C1: begin
            O_amp_a1 = a11_q;
            O_amp_a2 = a21_q;
         end
         ST_ISSUE_C2: begin
            O_amp_ena = 1'b1;
            O_amp_a1  = a12_q;
            O_amp_a2  = a22_q;
         end
         ST_WAIT_C2: begin
            O_amp_a1 = a12_q;
            O_amp_a2 = a22_q;
         end
         ST_DONE:     O_amps_valid = 1'b1;
         default: ;
      endcase
   end

   // Operand latches, result capture and overrun flag.
   always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
      if (!I_sys_rstn) begin
         a11_q     <= '0;
         a21_q     <= '0;
         a12_q     <= '0;
         a22_q     <= '0;
         col1_q    <= '0;
         col2_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= I_a_matrix_ready && (state_q != ST_IDLE);
         if (accept) begin
            a11_q <= I_a11;
            a21_q <= I_a21;
            a12_q <= I_a12;
            a22_q <= I_a22;
         end
         if (cap1) col1_q <= I_amp;
         if (cap2) col2_q <= I_amp;
      end
   end

   assign O_column_1_amp = col1_q;
   assign O_column_2_amp = col2_q;
   assign O_overrun      = overrun_q;
   assign O_dbg_state    = state_q;

endmodule

// File: tb/tb_amp_column_scheduler.sv
// -----------------------------------------------------------------------------
// tb_amp_column_scheduler
// Randomised bench for amp_column_scheduler. A behavioural shared modulus unit
// answers requests after a programmable latency; a cycle-level reference model
// tracks acceptance windows, and expected moduli plus their arrival cycle are
// queued for a separate monitor.
// -----------------------------------------------------------------------------
module tb_amp_column_scheduler;

   localparam int DW    = 16;
   localparam int AW    = DW + 1;
   localparam int TO    = 8;
   localparam int EXP_W = 32 + 2 * AW;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            ready;
   logic [DW-1:0]   a11, a21, a12, a22;
   logic            amp_ena;
   logic [DW-1:0]   amp_a1, amp_a2;
   logic [AW-1:0]   amp;
   logic            amp_valid;
   logic [AW-1:0]   col1, col2;
   logic            amps_valid, busy, overrun, timeout;
   amp_sched_pkg::amp_state_e dbg_state;

   // ---------------- clock / reset ----------------
   initial forever #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   amp_column_scheduler #(
      .DATA_W         (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .I_sys_clk        (clk),
      .I_sys_rstn       (rst_n),
      .I_a_matrix_ready (ready),
      .I_a11            (a11),
      .I_a21            (a21),
      .I_a12            (a12),
      .I_a22            (a22),
      .O_amp_ena        (amp_ena),
      .O_amp_a1         (amp_a1),
      .O_amp_a2         (amp_a2),
      .I_amp            (amp),
      .I_amp_valid      (amp_valid),
      .O_column_1_amp   (col1),
      .O_column_2_amp   (col2),
      .O_amps_valid     (amps_valid),
      .O_busy           (busy),
      .O_overrun        (overrun),
      .O_timeout        (timeout),
      .O_dbg_state      (dbg_state)
   );

   // ---------------- reference model state ----------------
   int checks = 0;
   int errors = 0;

   bit model_active = 1'b0;
   int acc_cyc = -100, busy_end = -100, ena1_cyc = -1, ena2_cyc = -1, to_cyc = -1;
   int lat = 4;
   int spur_cyc = -1;
   bit unit_mute = 1'b0;
   int rst_count = 0;
   int ovr_q[$];
   logic [EXP_W-1:0] exp_q[$];
   logic [AW-1:0] last_c1 = '0, last_c2 = '0;

   function automatic logic [AW-1:0] isqrt(input longint unsigned v);
      longint unsigned r;
      longint unsigned t;
      r = 0;
      for (int b = 18; b >= 0; b--) begin
         t = r | (64'd1 << b);
         if (t * t <= v) r = t;
      end
      return r[AW-1:0];
   endfunction

   function automatic logic [AW-1:0] modulus(input logic [DW-1:0] x, input logic [DW-1:0] y);
      return isqrt(64'(x) * 64'(x) + 64'(y) * 64'(y));
   endfunction

   function automatic logic [DW-1:0] rnd16();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         default: return DW'($urandom);
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_amp_ena"},    64'(amp_ena),    64'd0);
      check({tag, "_amp_a1"},     64'(amp_a1),     64'd0);
      check({tag, "_amp_a2"},     64'(amp_a2),     64'd0);
      check({tag, "_col1"},       64'(col1),       64'd0);
      check({tag, "_col2"},       64'(col2),       64'd0);
      check({tag, "_amps_valid"}, 64'(amps_valid), 64'd0);
      check({tag, "_busy"},       64'(busy),       64'd0);
      check({tag, "_overrun"},    64'(overrun),    64'd0);
      check({tag, "_timeout"},    64'(timeout),    64'd0);
      check({tag, "_state"},      64'(dbg_state),  64'd0);
   endtask

   // ---------------- driver tasks ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Drives one matrix-ready pulse in the current cycle and updates the model.
   task automatic issue_ready(input logic [DW-1:0] x11, input logic [DW-1:0] x21,
                              input logic [DW-1:0] x12, input logic [DW-1:0] x22,
                              input bit to_mode);
      logic [AW-1:0] r1, r2;
      ready = 1'b1;
      a11 = x11; a21 = x21; a12 = x12; a22 = x22;
      if (model_active && cyc >= acc_cyc + 1 && cyc <= busy_end) begin
         ovr_q.push_back(cyc + 1);
      end else begin
         model_active = 1'b1;
         acc_cyc      = cyc;
         ena1_cyc     = cyc + 1;
         if (to_mode) begin
            ena2_cyc = -1;
            to_cyc   = cyc + 1 + TO;
            busy_end = to_cyc;
         end else begin
            r1       = modulus(x11, x21);
            r2       = modulus(x12, x22);
            ena2_cyc = cyc + 2 + lat;
            busy_end = cyc + 3 + 2 * lat;
            to_cyc   = -1;
            exp_q.push_back({32'(busy_end), r1, r2});
            last_c1  = r1;
            last_c2  = r2;
         end
      end
      next_cycle();
      ready = 1'b0;
      a11 = rnd16(); a21 = rnd16(); a12 = rnd16(); a22 = rnd16();
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while (model_active && cyc <= busy_end) begin
         next_cycle();
         guard++;
         if (guard > 300) begin
            check("wait_idle_budget", 64'(guard), 64'd300);
            break;
         end
      end
   endtask

   // ---------------- behavioural shared modulus unit ----------------
   initial begin : shared_unit
      bit            pend;
      int            pend_cyc, pend_rst;
      logic [DW-1:0] op1, op2;
      logic [AW-1:0] pend_res;
      pend = 1'b0; pend_cyc = 0; pend_rst = 0; op1 = '0; op2 = '0; pend_res = '0;
      amp_valid = 1'b0;
      amp       = '0;
      forever begin
         next_cycle();
         amp_valid = 1'b0;
         amp       = '0;
         if (pend && cyc == pend_cyc) begin
            if (!unit_mute) begin
               amp_valid = 1'b1;
               amp       = pend_res;
               if (pend_rst == rst_count) begin
                  check("amp_a1_held", 64'(amp_a1), 64'(op1));
                  check("amp_a2_held", 64'(amp_a2), 64'(op2));
               end
            end
            pend = 1'b0;
         end else if (cyc == spur_cyc) begin
            amp_valid = 1'b1;
            amp       = '1;
         end
         if (amp_ena) begin
            pend     = 1'b1;
            pend_cyc = cyc + lat;
            pend_rst = rst_count;
            op1      = amp_a1;
            op2      = amp_a2;
            pend_res = modulus(amp_a1, amp_a2);
         end
      end
   end

   // ---------------- scoreboard monitor + per-cycle checks ----------------
   always @(negedge clk) begin : monitor
      logic [EXP_W-1:0] e;
      bit exp_busy, exp_ena, exp_ovr, exp_to;
      if (amps_valid) begin
         if (exp_q.size() == 0) begin
            check("amps_valid_unexpected", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("amps_valid_cycle", 64'(cyc), 64'(e[EXP_W-1 -: 32]));
            check("column_1_amp",     64'(col1), 64'(e[2*AW-1 -: AW]));
            check("column_2_amp",     64'(col2), 64'(e[AW-1:0]));
         end
      end
      exp_busy = model_active && (cyc >= acc_cyc + 1) && (cyc <= busy_end);
      exp_ena  = model_active && (cyc == ena1_cyc || cyc == ena2_cyc);
      exp_to   = model_active && (cyc == to_cyc);
      exp_ovr  = (ovr_q.size() > 0) && (ovr_q[0] == cyc);
      if (exp_ovr) void'(ovr_q.pop_front());
      check("busy",    64'(busy),    64'(exp_busy));
      check("amp_ena", 64'(amp_ena), 64'(exp_ena));
      check("overrun", 64'(overrun), 64'(exp_ovr));
      check("timeout", 64'(timeout), 64'(exp_to));
   end

   // ---------------- stimulus ----------------
   initial begin : stimulus
      int k, guard;
      rst_n = 1'b0;
      ready = 1'b0;
      a11 = '0; a21 = '0; a12 = '0; a22 = '0;
      repeat (3) next_cycle();
      check_all_zero("reset");
      rst_n = 1'b1;
      repeat (2) next_cycle();

      // Nominal, L=4: 3-4-5 and 5-12-13 triangles.
      lat = 4;
      issue_ready(16'd3, 16'd4, 16'd5, 16'd12, 1'b0);
      wait_idle();
      check("nominal_col1", 64'(col1), 64'd5);
      check("nominal_col2", 64'(col2), 64'd13);

      // Overrun: second ready three cycles after acceptance.
      issue_ready(rnd16(), rnd16(), rnd16(), rnd16(), 1'b0);
      repeat (2) next_cycle();
      issue_ready(rnd16(), rnd16(), rnd16(), rnd16(), 1'b0);
      wait_idle();

      // Spurious results in IDLE and in ISSUE_C1.
      spur_cyc = cyc + 1;
      repeat (3) next_cycle();
      check("spur_idle_col1", 64'(col1), 64'(last_c1));
      check("spur_idle_col2", 64'(col2), 64'(last_c2));
      spur_cyc = cyc + 1;
      issue_ready(rnd16(), rnd16(), rnd16(), rnd16(), 1'b0);
      wait_idle();
      spur_cyc = -1;

      // Randomised traffic with varying latency, gaps and dropped readies.
      for (int i = 0; i < 16; i++) begin
         lat = $urandom_range(1, 6);
         repeat ($urandom_range(0, 2)) next_cycle();
         issue_ready(rnd16(), rnd16(), rnd16(), rnd16(), 1'b0);
         if ($urandom_range(0, 3) == 0) begin
            k = $urandom_range(0, 2 * lat + 2);
            repeat (k) next_cycle();
            issue_ready(rnd16(), rnd16(), rnd16(), rnd16(), 1'b0);
         end
         wait_idle();
      end

      // Back-to-back, all elements at full scale, ready in the cycle after DONE.
      lat = $urandom_range(1, 6);
      for (int i = 0; i < 3; i++) begin
         issue_ready('1, '1, '1, '1, 1'b0);
         wait_idle();
      end
      check("max_col1", 64'(col1), 64'h16A08);
      check("max_col2", 64'(col2), 64'h16A08);

      // Reset asserted in WAIT_C2; the in-flight result lands after release.
      lat = 6;
      issue_ready(rnd16(), rnd16(), rnd16(), rnd16(), 1'b0);
      repeat (9) next_cycle();
      rst_n = 1'b0;
      model_active = 1'b0;
      exp_q.delete();
      ovr_q.delete();
      rst_count++;
      last_c1 = '0;
      last_c2 = '0;
      #1;
      check_all_zero("mid_reset");
      repeat (2) next_cycle();
      rst_n = 1'b1;
      repeat (12) next_cycle();
      check("post_reset_col1", 64'(col1), 64'd0);
      check("post_reset_col2", 64'(col2), 64'd0);
      lat = 3;
      issue_ready(rnd16(), rnd16(), rnd16(), rnd16(), 1'b0);
      wait_idle();

`ifdef AMP_SCHED_TIMEOUT_EN
      // Unit never answers: watchdog fires on the TO-th WAIT_C1 cycle.
      lat = 4;
      unit_mute = 1'b1;
      issue_ready(rnd16(), rnd16(), rnd16(), rnd16(), 1'b1);
      wait_idle();
      repeat (lat) next_cycle();
      unit_mute = 1'b0;
      check("timeout_col1_kept", 64'(col1), 64'(last_c1));
      check("timeout_col2_kept", 64'(col2), 64'(last_c2));
      issue_ready(rnd16(), rnd16(), rnd16(), rnd16(), 1'b0);
      wait_idle();
`endif

      // Drain the scoreboard with a bounded wait.
      guard = 0;
      while (exp_q.size() > 0 && guard < 200) begin
         next_cycle();
         guard++;
      end
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      check("overrun_queue_drained", 64'(ovr_q.size()), 64'd0);
      repeat (2) next_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/amp_column_scheduler.md
# amp_column_scheduler

Sequencer that shares one modulus unit (`get_amp`, sqrt(a1²+a2²), DATA_W in, DATA_W+1 out) between both columns of the 2×2 input matrix. On each matrix-ready pulse it latches a11, a21, a12 and a22. It then issues column 1 and column 2 to the shared unit in turn and captures both moduli. It presents them together with a single valid pulse to the downstream Givens/QR stage. A second `get_amp` instance is therefore not needed.

## Interface
- DATA_W, 16: element width; modulus width is DATA_W+1
- TIMEOUT_CYCLES, 64: watchdog limit per modulus request (used only with AMP_SCHED_TIMEOUT_EN)
- I_sys_clk  in  1  system clock, rising edge
- I_sys_rstn  in  1  asynchronous active-low reset
- I_a_matrix_ready  in  1  one-cycle pulse: matrix elements valid this cycle
- I_a11, I_a21, I_a12, I_a22  in  DATA_W each  matrix elements
- O_amp_ena  out  1  one-cycle request to the shared modulus unit
- O_amp_a1, O_amp_a2  out  DATA_W each  operands to the shared unit, held from request until result
- I_amp  in  DATA_W+1  modulus result from the shared unit
- I_amp_valid  in  1  one-cycle pulse: I_amp valid
- O_column_1_amp, O_column_2_amp  out  DATA_W+1 each  captured moduli
- O_amps_valid  out  1  one-cycle pulse: both moduli valid
- O_busy  out  1  high from the cycle after acceptance until O_amps_valid (inclusive)
- O_overrun  out  1  one-cycle pulse: matrix-ready was dropped because the block was busy
- O_timeout  out  1  one-cycle pulse: watchdog expired (AMP_SCHED_TIMEOUT_EN only; tied 0 otherwise)

## Operation
- States: IDLE, ISSUE_C1, WAIT_C1, ISSUE_C2, WAIT_C2, DONE.
- IDLE:
  - On I_a_matrix_ready=1, latch all four elements and go to ISSUE_C1.
- ISSUE_C1:
  - O_amp_ena=1, operands = (a11, a21).
  - Next state WAIT_C1.
- WAIT_C1:
  - Operands stay (a11, a21).
  - On I_amp_valid, capture I_amp into the column-1 register and go to ISSUE_C2.
- ISSUE_C2 and WAIT_C2:
  - Same as column 1, with operands (a12, a22).
  - Result is captured into the column-2 register, then go to DONE.
- DONE:
  - O_amps_valid=1 for one cycle, then IDLE.
- I_amp_valid outside WAIT_C1 or WAIT_C2 is ignored and captures nothing.
- I_a_matrix_ready in any state other than IDLE:
  - Data is not latched and no state change occurs.
  - O_overrun pulses the next cycle.
- Matrix-ready in DONE is also an overrun. It is not queued.
- O_column_x_amp hold their values until overwritten by the next capture. They are not cleared on IDLE.
- Outputs are registered: no combinational path from any input to any output.

## Timing
- Reset values:
  - State IDLE.
  - All outputs and latched operand registers 0.
- Ready accepted at cycle N → O_amp_ena high at N+1.
- Shared-unit latency L means I_amp_valid arrives at N+1+L. Column-2 O_amp_ena follows at N+2+L.
- O_amps_valid at N+3+2L, so end-to-end latency is 2L+3 cycles.
- I_amp_valid coincident with O_amp_ena (L=0) is not accepted. The unit must have L≥1.
- Back-to-back throughput: a new matrix is accepted at the earliest in the cycle after DONE.
- Reset asserted mid-operation:
  - Immediate return to IDLE with all outputs 0.
  - Any in-flight shared-unit result arriving after reset release is ignored.

## Configuration
- AMP_SCHED_TIMEOUT_EN defined:
  - A counter runs in WAIT_C1 and WAIT_C2 and reloads on entry to each.
  - If TIMEOUT_CYCLES elapse without I_amp_valid: O_timeout pulses, the column registers are left untouched, no O_amps_valid is issued, and the state goes to IDLE.
- Undefined:
  - No counter logic. O_timeout is constant 0.
  - WAIT states hold indefinitely.

## Structure
- Shared package amp_sched_pkg:
  - State enum and its encoding.
  - Default DATA_W.
  - AMP_W = DATA_W+1 derivation.
- One sub-module: amp_sched_watchdog (load/enable/expire counter), instantiated only under AMP_SCHED_TIMEOUT_EN.

## Test plan
- Nominal, L=4:
  - Stimulus: a11=3, a21=4, a12=5, a22=12.
  - O_column_1_amp=5 and O_column_2_amp=13.
  - O_amps_valid at N+11.
  - O_amp_ena pulses at N+1 and N+6.
- Overrun:
  - Stimulus: second matrix-ready at N+3.
  - O_overrun at N+4.
  - Results are still those of the first matrix.
  - O_busy stays high through DONE.
- Spurious I_amp_valid in IDLE and in ISSUE_C1, I_amp=0x1FFFF:
  - No capture.
  - Subsequent results are correct.
- Reset asserted in WAIT_C2:
  - All outputs 0 immediately.
  - A late I_amp_valid after release produces no O_amps_valid.
- AMP_SCHED_TIMEOUT_EN with TIMEOUT_CYCLES=8 and the unit never responding:
  - O_timeout at the 8th WAIT_C1 cycle.
  - Return to IDLE.
  - The next matrix completes normally.
- Back-to-back with maximum values:
  - Stimulus: a=0xFFFF on every element, ready issued in the cycle after DONE.
  - Accepted without overrun.
  - Moduli match the reference model at 17 bits.
